// File: rtl/serial_byte_subtractor.sv
// Multi-cycle A - B - bin, one SLICE-bit slice per clock, LSB slice first, valid/ready on both sides.
// Define SERIAL_SUB_ADD_MODE_EN to add an 'op' input selecting A + B + bin instead.
module serial_byte_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             OF
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;
    logic              of_q, of_d;
    logic              op_q, op_d;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE:0]    slice_res;
    logic              last_slice;
    logic              a_msb, b_msb, d_msb;

    // Handshake outputs come only from the state register.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign OF        = of_q;

    always_comb begin
        a_sl       = a_q[idx_q*SLICE +: SLICE];
        b_sl       = b_q[idx_q*SLICE +: SLICE];
        last_slice = (idx_q == IDXW'(NSLICE - 1));
        // Top bit of the (SLICE+1)-bit result is the borrow (or carry) into the next slice.
        if (op_q) begin
            slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, borrow_q};
        end else begin
            slice_res = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, borrow_q};
        end
        a_msb = a_q[WIDTH-1];
        b_msb = b_q[WIDTH-1];
        d_msb = slice_res[SLICE-1];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        of_d     = of_q;
        op_d     = op_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = bin;
                    idx_d    = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    op_d     = op;
`else
                    op_d     = 1'b0;
`endif
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                diff_d[idx_q*SLICE +: SLICE] = slice_res[SLICE-1:0];
                borrow_d = slice_res[SLICE];
                idx_d    = last_slice ? '0 : idx_q + IDXW'(1);
                if (last_slice) begin
                    bout_d  = slice_res[SLICE];
                    of_d    = op_q ? (~(a_msb ^ b_msb) & (d_msb ^ a_msb))
                                   : ((a_msb ^ b_msb) & (d_msb ^ a_msb));
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            of_q     <= 1'b0;
            op_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            of_q     <= of_d;
            op_q     <= op_d;
        end
    end

endmodule

// File: tb/tb_serial_byte_subtractor.sv
// Randomized self-checking bench for serial_byte_subtractor against a whole-word arithmetic model.
module tb_serial_byte_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        bin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        OF;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] last_diff;
    logic        last_bout;
    logic        last_of;

    serial_byte_subtractor #(
        .WIDTH(32),
        .SLICE(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .bin      (bin),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op       (op),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .OF       (OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: 33-bit arithmetic, flag rules taken on the sign bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                  input logic add, output logic [31:0] d, output logic bo,
                                  output logic of);
        logic [32:0] r;
        if (add) r = {1'b0, a} + {1'b0, b} + 33'(bi);
        else     r = {1'b0, a} - {1'b0, b} - 33'(bi);
        d  = r[31:0];
        bo = r[32];
        if (add) of = (a[31] == b[31]) && (d[31] != a[31]);
        else     of = (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, hold the result for 'hold' cycles, then retire it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input logic add, input int hold);
        logic [31:0] ed;
        logic        eb, eo;
        int          lat;
        model(a, b, bi, add, ed, eb, eo);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        A = a; B = b; bin = bi; op = add; in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            A = $urandom; B = $urandom; bin = 1'($urandom);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("out_valid", 32'(out_valid), 32'd1);
        check("diff", diff, ed);
        check("bout", 32'(bout), 32'(eb));
        check("of", 32'(OF), 32'(eo));
        last_diff = diff; last_bout = bout; last_of = OF;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_diff", diff, ed);
            check("hold_flags", {30'd0, bout, OF}, {30'd0, eb, eo});
        end
        // Offer new operands in the retire cycle; they must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rbi, rop;
        int          seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; bin = 1'b0; op = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_diff", diff, 32'd0);
        check("rst_flags", {30'd0, bout, OF}, 32'd0);

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 0);
        check("basic_diff", last_diff, 32'h0000_0002);
        check("basic_flags", {30'd0, last_bout, last_of}, 32'd0);

        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 0);
        check("chain_diff", last_diff, 32'hFFFF_FFFF);
        check("chain_flags", {30'd0, last_bout, last_of}, {30'd0, 1'b1, 1'b0});

        run_op(32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 0);
        check("binchain_diff", last_diff, 32'h0000_00FF);
        check("binchain_bout", 32'(last_bout), 32'd0);

        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 0);
        check("ovf1_diff", last_diff, 32'h7FFF_FFFF);
        check("ovf1_flags", {30'd0, last_bout, last_of}, {30'd0, 1'b0, 1'b1});

        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        check("ovf2_diff", last_diff, 32'h8000_0000);
        check("ovf2_flags", {30'd0, last_bout, last_of}, {30'd0, 1'b1, 1'b1});

        // Backpressure, then a back-to-back operation.
        run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 5);
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 0);

        // Reset during the second BUSY cycle aborts the operation.
        A = 32'h1234_5678; B = 32'h0101_0101; bin = 1'b0; op = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_diff", diff, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_op(32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0, 0);
        check("fresh_diff", last_diff, 32'h1133_5577);

        for (int n = 0; n < 60; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rbi = 1'($urandom);
`ifdef SERIAL_SUB_ADD_MODE_EN
            rop = 1'($urandom);
`else
            rop = 1'b0;
`endif
            if (n % 7 == 0) rb = ra;
            run_op(ra, rb, rbi, rop, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_byte_subtractor.md
Name: serial_byte_subtractor

Overview:
- Multi-cycle 32-bit two's-complement subtractor: computes A - B - bin one 8-bit slice per clock, least-significant slice first.
- A registered borrow chain links the slices.
- Companion to the combinational carry-increment adder: it supplies the subtract direction for the datapath in area-constrained builds.
- valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle. NSLICE = WIDTH/SLICE (default 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands A, B, bin present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  A - B - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 iff A < B + bin, unsigned.
- OF  output  1  signed overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, slice index=0, borrow=0.
  - diff=0, bout=0, OF=0, out_valid=0, in_ready=1 from the next cycle.
  - Reset mid-operation aborts the operation; no out_valid is produced.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture A, B, bin into internal registers; set borrow=bin, idx=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle compute {b, d} = A[idx slice] - B[idx slice] - borrow, SLICE+1 bits. Write d into diff[idx slice], set borrow=b, idx=idx+1. On the cycle idx==NSLICE-1: set bout=b, compute OF, go to DONE.
  - DONE: out_valid=1, in_ready=0. diff, bout and OF are held stable. On out_valid&&out_ready, go to IDLE; out_valid falls on the next cycle.
- OF = (A[MSB]^B[MSB]) & (diff[MSB]^A[MSB]), using the captured A and B.
- Latency: operands accepted at edge k give out_valid=1 after edge k+NSLICE (4 cycles).
- Minimum issue interval is NSLICE+2 cycles, because in_ready is asserted only in IDLE.
- Operand inputs are ignored outside the accept cycle; changes to A/B during BUSY have no effect.
- diff is meaningful only while out_valid=1. During BUSY it shows partially written slices.
- out_ready held high entering DONE: out_valid is high for exactly one cycle.
- in_valid and out_ready asserted together in DONE: the result retires and the new operands are not accepted in that cycle.
- No combinational path from in_valid or out_ready to in_ready or out_valid; both are decoded from the state register.

Optional Feature:
- Macro SERIAL_SUB_ADD_MODE_EN.
- When defined:
  - Adds input port op (1 bit), captured with the operands.
  - op=0: subtract, exactly as above.
  - op=1: add A + B + bin; bin acts as carry-in and bout reports carry-out.
  - OF uses the add rule: ~(A[MSB]^B[MSB]) & (diff[MSB]^A[MSB]).
- When undefined: no op port; the block always subtracts.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release. Required: out_valid=0, in_ready=1, diff=0, bout=0, OF=0.
- Basic subtract: A=0x00000005, B=0x00000003, bin=0, out_ready=1. Required: out_valid 4 cycles after accept, diff=0x00000002, bout=0, OF=0, in_ready=0 for the whole operation.
- Full borrow chain: A=0x00000000, B=0x00000001, bin=0. Required: diff=0xFFFFFFFF, bout=1, OF=0. Separately, A=0x00000100, B=0, bin=1. Required: diff=0x000000FF, bout=0.
- Signed overflow: A=0x80000000, B=0x00000001, bin=0. Required: diff=0x7FFFFFFF, OF=1, bout=0. Separately, A=0x7FFFFFFF, B=0xFFFFFFFF. Required: diff=0x80000000, OF=1, bout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_valid=1 throughout, diff/bout/OF stable, in_ready=0. Then raise out_ready. Required: retire; in_ready=1 the following cycle; the next operands accept normally.
- Reset mid-operation: drive rst_n=0 during BUSY cycle 2 of A=0x12345678, B=0x01010101. Required: no out_valid pulse, IDLE with in_ready=1. A fresh operation then gives diff=0x11335577.
